// File: rtl/adder_pipelined_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined add/sub unit.
// Chunk width derivation and the WIDTH/STAGES legality rule live here.
package adder_pipelined_addsub_pkg;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit stages_legal(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CW-bit ripple-carry adder slice built from discrete full-adder gates.
// Also exposes the carry into its MSB for overflow cross-checking.
module adder_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          c_msb_in
);

  for (genvar i = 0; i < CW; i++) begin : g_fa
    logic c_in;
    logic p;
    logic c_out;
    if (i == 0) begin : g_cin
      assign c_in = ci;
    end else begin : g_cin
      assign c_in = g_fa[i-1].c_out;
    end
    assign p     = a[i] ^ b[i];
    assign s[i]  = p ^ c_in;
    assign c_out = (a[i] & b[i]) | (p & c_in);
  end

  assign co       = g_fa[CW-1].c_out;
  assign c_msb_in = g_fa[CW-1].c_in;

endmodule

// File: rtl/adder_pipelined_addsub.sv
// Pipelined add/subtract unit: one ripple chunk resolved per stage,
// carry and unresolved operand slices skewed through stage registers.
module adder_pipelined_addsub
  import adder_pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!stages_legal(WIDTH, STAGES)) begin : g_bad
    $error("adder_pipelined_addsub: WIDTH must be a multiple of STAGES");
  end

  logic   advance;
  flags_t flg_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign cout = flg_q.cout;
  assign ovf  = flg_q.ovf;
  assign zero = flg_q.zero;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int RW = WIDTH - s * CW;

    logic [RW-1:0]         a_i;
    logic [RW-1:0]         b_i;
    logic                  c_i;
    logic                  v_i;
    logic [CW-1:0]         cs;
    logic                  co;
    logic                  unused_cmsb;
    logic [(s+1)*CW-1:0]   s_n;

    if (s == 0) begin : g_src
      assign a_i = A;
      assign b_i = sub ? ~B : B;
      assign c_i = sub | cin;
      assign v_i = in_valid;
      assign s_n = cs;
    end else begin : g_src
      assign a_i = g_st[s-1].g_r.a_q;
      assign b_i = g_st[s-1].g_r.b_q;
      assign c_i = g_st[s-1].g_r.c_q;
      assign v_i = g_st[s-1].g_r.v_q;
      assign s_n = {cs, g_st[s-1].g_r.s_q};
    end

    // Chunk s always consumes the lowest remaining operand slice
    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .a       (a_i[CW-1:0]),
      .b       (b_i[CW-1:0]),
      .ci      (c_i),
      .s       (cs),
      .co      (co),
      .c_msb_in(unused_cmsb)
    );

    if (s < STAGES - 1) begin : g_r
      logic                v_q;
      logic                c_q;
      logic [RW-CW-1:0]    a_q;
      logic [RW-CW-1:0]    b_q;
      logic [(s+1)*CW-1:0] s_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          s_q <= '0;
        end else if (advance) begin
          v_q <= v_i;
          c_q <= co;
          a_q <= a_i[RW-1:CW];
          b_q <= b_i[RW-1:CW];
          s_q <= s_n;
        end
      end
    end else begin : g_out
      flags_t flg_n;

      always_comb begin
        flg_n      = '0;
        flg_n.cout = co;
        flg_n.ovf  = (a_i[RW-1] == b_i[RW-1]) &&
                     (cs[CW-1] != a_i[RW-1]);
        flg_n.zero = ~|s_n;
      end

      // Result fields only move on a valid result so they stay clean
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          Sum       <= '0;
          flg_q     <= '0;
        end else if (advance) begin
          out_valid <= v_i;
          if (v_i) begin
            Sum   <= s_n;
            flg_q <= flg_n;
          end
        end
      end
    end
  end

endmodule
